// File: rtl/cordic_atan2_if.sv
// Operand/result handshake bundle for the CORDIC atan2 engine.
// The producer drives the operand pair and out_ready; the engine drives everything else.
interface cordic_atan2_if #(
  parameter int WIDTH = 16
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] x_in;
  logic signed [WIDTH-1:0] y_in;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [WIDTH-1:0] angle_out;
  logic        [WIDTH+1:0] mag_out;

  modport master (
    output in_valid, x_in, y_in, out_ready,
    input  in_ready, out_valid, angle_out, mag_out
  );

  modport slave (
    input  in_valid, x_in, y_in, out_ready,
    output in_ready, out_valid, angle_out, mag_out
  );
endinterface

// File: rtl/cordic_atan2.sv
// Iterative vectoring-mode CORDIC: full-quadrant atan2(y,x) in Q3.(WIDTH-3) radians plus
// the gain-scaled magnitude, one micro-rotation per clock.
module cordic_atan2 #(
  parameter int WIDTH = 16,
  parameter int ITER  = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  cordic_atan2_if.slave bus,
  output logic          busy
);

  localparam int FRAC = WIDTH - 3;
  localparam int CW   = $clog2(ITER);

  // pi * 2^62, rounded; every angle constant is derived from this fixed-point reference
  localparam logic [63:0] PI_Q62 = 64'hC90FDAA22168C235;

  function automatic logic [63:0] round_shift(input logic [63:0] v, input int sh);
    return (v + (64'd1 << (sh - 1))) >> sh;
  endfunction

  // atan(2^-i) in Q60: odd-power series whose terms are exact powers of two divided by 2k+1
  function automatic logic [63:0] atan_q60(input int i);
    logic [63:0] acc;
    int          e;
    acc = 64'd0;
    if (i == 0) begin
      acc = PI_Q62 >> 4;
    end else begin
      for (int k = 0; k < 32; k++) begin
        e = 60 - i * (2 * k + 1);
        if (e >= 0) begin
          if (k % 2 == 0) acc = acc + ((64'd1 << e) / 64'(2 * k + 1));
          else            acc = acc - ((64'd1 << e) / 64'(2 * k + 1));
        end
      end
    end
    return acc;
  endfunction

  localparam logic signed [WIDTH:0] PI_Q     = (WIDTH+1)'(round_shift(PI_Q62, 62 - FRAC));
  localparam logic signed [WIDTH:0] NEG_PI_Q = -PI_Q;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic signed [WIDTH:0]   atan_tab [ITER];
  for (genvar g = 0; g < ITER; g++) begin : g_tab
    assign atan_tab[g] = (WIDTH+1)'(round_shift(atan_q60(g), 60 - FRAC));
  end

  logic [1:0]              state;
  logic [CW-1:0]           cnt;
  logic signed [WIDTH+1:0] xr, yr;
  logic signed [WIDTH:0]   zr;
  logic                    zero_flag;
  logic signed [WIDTH-1:0] angle_q;
  logic        [WIDTH+1:0] mag_q;

  logic signed [WIDTH+1:0] x_ext, y_ext, x_pre, y_pre;
  logic signed [WIDTH:0]   z_pre;
  logic signed [WIDTH+1:0] xs, ys, x_nx, y_nx;
  logic signed [WIDTH:0]   z_nx;
  logic signed [WIDTH-1:0] angle_sat;

  // Fold the left half-plane onto the right so the iteration only has to cover +-pi/2
  always_comb begin
    x_ext = {{2{bus.x_in[WIDTH-1]}}, bus.x_in};
    y_ext = {{2{bus.y_in[WIDTH-1]}}, bus.y_in};
    x_pre = x_ext;
    y_pre = y_ext;
    z_pre = '0;
    if (bus.x_in[WIDTH-1]) begin
      x_pre = -x_ext;
      y_pre = -y_ext;
      z_pre = bus.y_in[WIDTH-1] ? NEG_PI_Q : PI_Q;
    end
  end

  // One micro-rotation driving yr toward zero; both shifts use the pre-update registers
  always_comb begin
    xs = xr >>> cnt;
    ys = yr >>> cnt;
    if (!yr[WIDTH+1]) begin
      x_nx = xr + ys;
      y_nx = yr - xs;
      z_nx = zr + atan_tab[cnt];
    end else begin
      x_nx = xr - ys;
      y_nx = yr + xs;
      z_nx = zr - atan_tab[cnt];
    end
    if (z_nx > PI_Q)           angle_sat = PI_Q[WIDTH-1:0];
    else if (z_nx < NEG_PI_Q)  angle_sat = NEG_PI_Q[WIDTH-1:0];
    else                       angle_sat = z_nx[WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      xr        <= '0;
      yr        <= '0;
      zr        <= '0;
      zero_flag <= 1'b0;
      angle_q   <= '0;
      mag_q     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            xr        <= x_pre;
            yr        <= y_pre;
            zr        <= z_pre;
            cnt       <= '0;
            zero_flag <= (bus.x_in == '0) && (bus.y_in == '0);
            state     <= S_RUN;
          end
        end
        S_RUN: begin
          xr  <= x_nx;
          yr  <= y_nx;
          zr  <= z_nx;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(ITER - 1)) begin
            angle_q <= zero_flag ? '0 : angle_sat;
            mag_q   <= zero_flag ? '0 : $unsigned(x_nx);
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE);
  assign bus.out_valid = (state == S_DONE);
  assign busy          = (state != S_IDLE);
  assign bus.angle_out = angle_q;
  assign bus.mag_out   = mag_q;

endmodule
